fifo_ctrl: RTL and testbench

- Control sequencer for the synchronous FIFO.
- Owns the read and write pointers and the FIFO state machine.
- Drives the up/down occupancy counter's enable and direction, and the storage RAM write/read strobes and addresses.
- Accepts or rejects push/pop requests and reports full/empty, watermark and sticky error flags to the producer and consumer.

---
 rtl/fifo_ctrl.sv | 144 ++++++++++++++
 tb/tb_fifo_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_ctrl.sv
// fifo_ctrl: control sequencer for a synchronous FIFO.
// It owns the read/write pointers, the occupancy count and the fill-state
// FSM. It gates push/pop requests against the registered full/empty flags,
// drives the RAM strobes and the external up/down counter controls, and
// keeps sticky overflow/underflow error flags.
//
// state     | meaning
// ----------+--------------------------------------------
// S_EMPTY   | no entries held; pops are rejected
// S_PARTIAL | 1..DEPTH-1 entries held
// S_FULL    | DEPTH entries held; pushes are rejected
module fifo_ctrl #(
  parameter int ADDR_W = 4,
  parameter int AF_LVL = 14,
  parameter int AE_LVL = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic              err_clr_i,
  output logic              wr_en_o,
  output logic              rd_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  output logic              cnt_enb_o,
  output logic              updn_cnt_o,
  output logic [ADDR_W:0]   count_o,
  output logic              full_o,
  output logic              empty_o,
  output logic              almost_full_o,
  output logic              almost_empty_o,
  output logic              overflow_o,
  output logic              underflow_o
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int CNT_W = ADDR_W + 1;

  localparam logic [1:0] S_EMPTY   = 2'b00;
  localparam logic [1:0] S_PARTIAL = 2'b01;
  localparam logic [1:0] S_FULL    = 2'b10;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_TOP  = CNT_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] AF_THR   = CNT_W'(AF_LVL);
  localparam logic [CNT_W-1:0] AE_THR   = CNT_W'(AE_LVL);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              af_q, af_d;
  logic              ae_q, ae_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              full_w, empty_w;
  logic              push_ok, pop_ok;

  // Flags come straight from the state register, so acceptance never
  // depends on the same-cycle request (no push-through / pop-through).
  assign full_w  = (state_q == S_FULL);
  assign empty_w = (state_q == S_EMPTY);

  assign push_ok = push_i & ~full_w;
  assign pop_ok  = pop_i  & ~empty_w;

  assign wr_en_o    = push_ok;
  assign rd_en_o    = pop_ok;
  assign cnt_enb_o  = push_ok ^ pop_ok;
  assign updn_cnt_o = push_ok & ~pop_ok;

  // Next-state for pointers, count, watermarks and sticky errors.
  always_comb begin
    wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop_ok  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    // Watermarks use the next count so they line up with count_o.
    af_d  = (count_d >= AF_THR);
    ae_d  = (count_d <= AE_THR);
    // Set beats clear when both happen in the same cycle.
    ovf_d = (push_i & full_w)  | (ovf_q & ~err_clr_i);
    unf_d = (pop_i  & empty_w) | (unf_q & ~err_clr_i);
  end

  // Fill-state transitions.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_EMPTY: begin
        if (push_ok) state_d = S_PARTIAL;
      end
      S_PARTIAL: begin
        if (push_ok && !pop_ok && count_q == CNT_TOP)
          state_d = S_FULL;
        else if (pop_ok && !push_ok && count_q == CNT_ONE)
          state_d = S_EMPTY;
      end
      S_FULL: begin
        if (pop_ok) state_d = S_PARTIAL;
      end
      default: state_d = S_EMPTY;
    endcase
  end

  // Register all control state; reset returns to an empty FIFO.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_EMPTY;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      af_q     <= 1'b0;
      ae_q     <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      af_q     <= af_d;
      ae_q     <= ae_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  assign wr_addr_o      = wr_ptr_q;
  assign rd_addr_o      = rd_ptr_q;
  assign count_o        = count_q;
  assign full_o         = full_w;
  assign empty_o        = empty_w;
  assign almost_full_o  = af_q;
  assign almost_empty_o = ae_q;
  assign overflow_o     = ovf_q;
  assign underflow_o    = unf_q;

endmodule

// File: tb/tb_fifo_ctrl.sv
// tb_fifo_ctrl: scoreboard bench for fifo_ctrl. The reference model holds
// the FIFO as a queue of tokens plus running push/pop totals; a monitor
// process pops expectations and compares them with the DUT each cycle.
module tb_fifo_ctrl;

  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;
  localparam int AF_LVL = 14;
  localparam int AE_LVL = 2;

  logic              clk_i = 1'b0;
  logic              rst_ni = 1'b0;
  logic              push_i = 1'b0;
  logic              pop_i = 1'b0;
  logic              err_clr_i = 1'b0;
  logic              wr_en_o, rd_en_o, cnt_enb_o, updn_cnt_o;
  logic [ADDR_W-1:0] wr_addr_o, rd_addr_o;
  logic [ADDR_W:0]   count_o;
  logic              full_o, empty_o, almost_full_o, almost_empty_o;
  logic              overflow_o, underflow_o;

  fifo_ctrl #(.ADDR_W(ADDR_W), .AF_LVL(AF_LVL), .AE_LVL(AE_LVL)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .push_i(push_i), .pop_i(pop_i),
    .err_clr_i(err_clr_i), .wr_en_o(wr_en_o), .rd_en_o(rd_en_o),
    .wr_addr_o(wr_addr_o), .rd_addr_o(rd_addr_o), .cnt_enb_o(cnt_enb_o),
    .updn_cnt_o(updn_cnt_o), .count_o(count_o), .full_o(full_o),
    .empty_o(empty_o), .almost_full_o(almost_full_o),
    .almost_empty_o(almost_empty_o), .overflow_o(overflow_o),
    .underflow_o(underflow_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int wr_en, rd_en, cnt_enb, updn;
    int wa, ra, cnt, full, empty, af, ae, ovf, unf;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  // Reference model: FIFO contents as a token queue, pointers as totals.
  int   fifo_m[$];
  int   pushes_m = 0;
  int   pops_m = 0;
  int   ovf_m = 0;
  int   unf_m = 0;
  int   token = 0;

  task automatic chk(input string name, input int act, input int expv);
    tests++;
    if (act != expv) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  task automatic model_reset();
    fifo_m.delete();
    pushes_m = 0;
    pops_m = 0;
    ovf_m = 0;
    unf_m = 0;
  endtask

  // Drive one cycle of stimulus and queue what the DUT must show.
  task automatic step(input bit p, input bit q, input bit clr);
    exp_t e;
    int   was_full, was_empty, pok, qok;
    @(negedge clk_i);
    push_i = p;
    pop_i = q;
    err_clr_i = clr;
    was_full  = (fifo_m.size() == DEPTH);
    was_empty = (fifo_m.size() == 0);
    pok = (p && !was_full) ? 1 : 0;
    qok = (q && !was_empty) ? 1 : 0;
    e.wr_en = pok;
    e.rd_en = qok;
    e.cnt_enb = (pok != qok) ? 1 : 0;
    e.updn = (pok == 1 && qok == 0) ? 1 : 0;
    if (qok == 1) void'(fifo_m.pop_front());
    if (pok == 1) begin
      fifo_m.push_back(token);
      token++;
    end
    pushes_m += pok;
    pops_m += qok;
    ovf_m = ((p && was_full) || (ovf_m == 1 && !clr)) ? 1 : 0;
    unf_m = ((q && was_empty) || (unf_m == 1 && !clr)) ? 1 : 0;
    e.wa = pushes_m % DEPTH;
    e.ra = pops_m % DEPTH;
    e.cnt = fifo_m.size();
    e.full = (fifo_m.size() == DEPTH) ? 1 : 0;
    e.empty = (fifo_m.size() == 0) ? 1 : 0;
    e.af = (fifo_m.size() >= AF_LVL) ? 1 : 0;
    e.ae = (fifo_m.size() <= AE_LVL) ? 1 : 0;
    e.ovf = ovf_m;
    e.unf = unf_m;
    exp_q.push_back(e);
  endtask

  // Monitor: strobes mid-cycle, registered outputs just after the edge.
  initial begin
    exp_t e;
    int   s_wr, s_rd, s_en, s_ud;
    forever begin
      @(negedge clk_i);
      #2;
      if (exp_q.size() > 0) begin
        s_wr = int'(wr_en_o);
        s_rd = int'(rd_en_o);
        s_en = int'(cnt_enb_o);
        s_ud = int'(updn_cnt_o);
        @(posedge clk_i);
        #1;
        e = exp_q.pop_front();
        chk("wr_en", s_wr, e.wr_en);
        chk("rd_en", s_rd, e.rd_en);
        chk("cnt_enb", s_en, e.cnt_enb);
        chk("updn_cnt", s_ud, e.updn);
        chk("wr_addr", int'(wr_addr_o), e.wa);
        chk("rd_addr", int'(rd_addr_o), e.ra);
        chk("count", int'(count_o), e.cnt);
        chk("full", int'(full_o), e.full);
        chk("empty", int'(empty_o), e.empty);
        chk("almost_full", int'(almost_full_o), e.af);
        chk("almost_empty", int'(almost_empty_o), e.ae);
        chk("overflow", int'(overflow_o), e.ovf);
        chk("underflow", int'(underflow_o), e.unf);
      end
    end
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_wr_addr"}, int'(wr_addr_o), 0);
    chk({tag, "_rd_addr"}, int'(rd_addr_o), 0);
    chk({tag, "_count"}, int'(count_o), 0);
    chk({tag, "_empty"}, int'(empty_o), 1);
    chk({tag, "_full"}, int'(full_o), 0);
    chk({tag, "_almost_empty"}, int'(almost_empty_o), 1);
    chk({tag, "_almost_full"}, int'(almost_full_o), 0);
    chk({tag, "_overflow"}, int'(overflow_o), 0);
    chk({tag, "_underflow"}, int'(underflow_o), 0);
    chk({tag, "_wr_en"}, int'(wr_en_o), 0);
    chk({tag, "_rd_en"}, int'(rd_en_o), 0);
    chk({tag, "_cnt_enb"}, int'(cnt_enb_o), 0);
    chk({tag, "_updn_cnt"}, int'(updn_cnt_o), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish by 200000");
    $fatal(1, "bench timeout");
  end

  initial begin
    model_reset();
    repeat (3) @(posedge clk_i);
    #2;
    chk_reset_vals("rst");
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Idle, then fill to full, overflow, clear.
    repeat (3) step(0, 0, 0);
    repeat (DEPTH) step(1, 0, 0);
    step(1, 0, 0);
    step(0, 0, 1);

    // Drain to empty, underflow, clear.
    repeat (DEPTH) step(0, 1, 0);
    step(0, 1, 0);
    step(0, 0, 1);

    // Steady state at count 5 with simultaneous push and pop.
    repeat (5) step(1, 0, 0);
    repeat (20) step(1, 1, 0);
    while (fifo_m.size() > 0) step(0, 1, 0);

    // Random traffic: fill-biased phase, then drain-biased phase.
    for (int i = 0; i < 300; i++) begin
      bit p, q, c;
      if (i < 150) begin
        p = ($urandom_range(0, 99) < 75);
        q = ($urandom_range(0, 99) < 35);
      end else begin
        p = ($urandom_range(0, 99) < 30);
        q = ($urandom_range(0, 99) < 75);
      end
      c = ($urandom_range(0, 99) < 6);
      step(p, q, c);
    end

    // Bring occupancy to 9, then reset asynchronously mid-burst.
    while (fifo_m.size() > 0) step(0, 1, 0);
    step(0, 0, 1);
    repeat (9) step(1, 0, 0);
    @(posedge clk_i);
    #3;
    chk("pre_reset_count", int'(count_o), 9);
    rst_ni = 1'b0;
    push_i = 1'b0;
    pop_i = 1'b0;
    err_clr_i = 1'b0;
    #1;
    chk_reset_vals("async");
    model_reset();
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Resume from empty after release.
    repeat (4) step(1, 0, 0);
    repeat (3) step(1, 1, 0);
    step(0, 1, 0);

    repeat (2) @(posedge clk_i);
    #3;
    chk("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
